midi_msg_parser: RTL

// - Consumes the byte stream from the UART receiver (1-cycle valid strobe + 8-bit byte); assembles complete MIDI messages.
// - Handles running status, real-time interleaving and SysEx streaming.
// - Emits one strobe per complete channel/system-common message to the router core.
// - Real-time bytes go out on a separate low-latency strobe.

---
 rtl/midi_pkg.sv | 46 ++++
 rtl/midi_status_decode.sv | 20 ++
 rtl/midi_msg_parser.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI status constants, parser states and data-length helper
package midi_pkg;

  // Channel voice status classes (upper nibble, channel in the low nibble)
  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] POLY_AT     = 8'hA0;
  localparam logic [7:0] CTRL_CHG    = 8'hB0;
  localparam logic [7:0] PROG_CHG    = 8'hC0;
  localparam logic [7:0] CHAN_AT     = 8'hD0;
  localparam logic [7:0] PITCH_BEND  = 8'hE0;

  // System common / exclusive
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] MTC_QF      = 8'hF1;
  localparam logic [7:0] SONG_POS    = 8'hF2;
  localparam logic [7:0] SONG_SEL    = 8'hF3;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  // Real-time bytes are F8..FF
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Parser state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_D1  = 2'd1;
  localparam logic [1:0] ST_WAIT_D2  = 2'd2;
  localparam logic [1:0] ST_SYSEX    = 2'd3;

  // Number of data bytes that follow a status byte; 0 for anything without a payload
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7:4] == PROG_CHG[7:4] || status[7:4] == CHAN_AT[7:4]) begin
      len = 2'd1;
    end else if (status[7] && status[7:4] != 4'hF) begin
      len = 2'd2;
    end else if (status == SONG_POS) begin
      len = 2'd2;
    end else if (status == MTC_QF || status == SONG_SEL) begin
      len = 2'd1;
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// rtl/midi_status_decode.sv - combinational classification of one received MIDI byte
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0] rx_byte,
  output logic       is_status,
  output logic       is_realtime,
  output logic       is_channel,
  output logic [1:0] data_len,
  output logic       is_undefined
);

  // Status bytes proper exclude real-time, which is handled on its own path
  assign is_status    = rx_byte[7] && (rx_byte < RT_MIN);
  assign is_realtime  = (rx_byte >= RT_MIN);
  assign is_channel   = (rx_byte >= NOTE_OFF) && (rx_byte < SYSEX_START);
  assign data_len     = midi_data_len(rx_byte);
  assign is_undefined = (rx_byte == 8'hF4) || (rx_byte == 8'hF5);

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - assembles MIDI messages with running status, real-time and SysEx streaming
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit ERR_ON_ABORT = 1'b1
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Msg_Valid,
  output logic [7:0] o_Status,
  output logic [6:0] o_Data1,
  output logic [6:0] o_Data2,
  output logic [1:0] o_Msg_Len,
  output logic       o_Rt_Valid,
  output logic [7:0] o_Rt_Byte,
  output logic       o_Sx_Valid,
  output logic [7:0] o_Sx_Byte,
  output logic       o_Sx_Last,
  output logic       o_Err
);

  logic       is_status, is_realtime, is_channel, is_undefined;
  logic [1:0] byte_len;

  midi_status_decode u_decode (
    .rx_byte      (i_Rx_Byte),
    .is_status    (is_status),
    .is_realtime  (is_realtime),
    .is_channel   (is_channel),
    .data_len     (byte_len),
    .is_undefined (is_undefined)
  );

  logic [1:0] state_q, state_d;
  logic       run_valid_q, run_valid_d;
  logic [7:0] run_status_q, run_status_d;
  logic [7:0] cur_status_q, cur_status_d;
  logic [6:0] d1_q, d1_d;

  logic       msg_valid_d, rt_valid_d, sx_valid_d, sx_last_d, err_d;
  logic [7:0] status_d, rt_byte_d, sx_byte_d;
  logic [6:0] data1_d, data2_d;
  logic [1:0] len_d;
  logic       start_status;
  logic [7:0] d1_status;

  // Status that a data byte in IDLE/WAIT_D1 belongs to: the pending one, else running status
  assign d1_status = (state_q == ST_WAIT_D1) ? cur_status_q : run_status_q;

  // Next-state and next-output decision for one received byte
  always_comb begin
    state_d      = state_q;
    run_valid_d  = run_valid_q;
    run_status_d = run_status_q;
    cur_status_d = cur_status_q;
    d1_d         = d1_q;
    msg_valid_d  = 1'b0;
    status_d     = o_Status;
    data1_d      = o_Data1;
    data2_d      = o_Data2;
    len_d        = o_Msg_Len;
    rt_valid_d   = 1'b0;
    rt_byte_d    = o_Rt_Byte;
    sx_valid_d   = 1'b0;
    sx_byte_d    = o_Sx_Byte;
    sx_last_d    = 1'b0;
    err_d        = 1'b0;
    start_status = 1'b0;

    if (i_Rx_DV) begin
      if (is_realtime) begin
        // Real-time bytes bypass the parser entirely
        rt_valid_d = 1'b1;
        rt_byte_d  = i_Rx_Byte;
      end else if (is_status) begin
        start_status = 1'b1;
        case (state_q)
          ST_SYSEX: begin
            // Any status ends SysEx; a non-F7 one is reported as a synthetic F7 abort
            sx_valid_d = 1'b1;
            sx_byte_d  = SYSEX_END;
            sx_last_d  = 1'b1;
            state_d    = ST_IDLE;
            if (i_Rx_Byte == SYSEX_END) begin
              start_status = 1'b0;
              run_valid_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
          ST_WAIT_D1, ST_WAIT_D2: begin
            err_d   = ERR_ON_ABORT;
            state_d = ST_IDLE;
          end
          default: ;
        endcase

        if (start_status) begin
          run_valid_d = is_channel;
          if (is_channel) begin
            run_status_d = i_Rx_Byte;
          end
          state_d = ST_IDLE;
          if (i_Rx_Byte == SYSEX_START) begin
            state_d = ST_SYSEX;
            // When F0 aborts a running SysEx the sx port already carries the abort F7
            if (state_q != ST_SYSEX) begin
              sx_valid_d = 1'b1;
              sx_byte_d  = SYSEX_START;
            end
          end else if (i_Rx_Byte == TUNE_REQ) begin
            msg_valid_d = 1'b1;
            status_d    = i_Rx_Byte;
            data1_d     = 7'd0;
            data2_d     = 7'd0;
            len_d       = 2'd0;
          end else if (is_undefined) begin
            state_d = ST_IDLE;
          end else if (byte_len != 2'd0) begin
            cur_status_d = i_Rx_Byte;
            state_d      = ST_WAIT_D1;
          end
        end
      end else begin
        case (state_q)
          ST_SYSEX: begin
            sx_valid_d = 1'b1;
            sx_byte_d  = i_Rx_Byte;
          end
          ST_WAIT_D2: begin
            msg_valid_d = 1'b1;
            status_d    = cur_status_q;
            data1_d     = d1_q;
            data2_d     = i_Rx_Byte[6:0];
            len_d       = 2'd2;
            state_d     = ST_IDLE;
          end
          default: begin
            if (state_q == ST_WAIT_D1 || run_valid_q) begin
              if (midi_data_len(d1_status) == 2'd1) begin
                msg_valid_d = 1'b1;
                status_d    = d1_status;
                data1_d     = i_Rx_Byte[6:0];
                data2_d     = 7'd0;
                len_d       = 2'd1;
                state_d     = ST_IDLE;
              end else begin
                cur_status_d = d1_status;
                d1_d         = i_Rx_Byte[6:0];
                state_d      = ST_WAIT_D2;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Parser state and registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      run_valid_q  <= 1'b0;
      run_status_q <= 8'd0;
      cur_status_q <= 8'd0;
      d1_q         <= 7'd0;
      o_Msg_Valid  <= 1'b0;
      o_Status     <= 8'd0;
      o_Data1      <= 7'd0;
      o_Data2      <= 7'd0;
      o_Msg_Len    <= 2'd0;
      o_Rt_Valid   <= 1'b0;
      o_Rt_Byte    <= 8'd0;
      o_Sx_Valid   <= 1'b0;
      o_Sx_Byte    <= 8'd0;
      o_Sx_Last    <= 1'b0;
      o_Err        <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_valid_q  <= run_valid_d;
      run_status_q <= run_status_d;
      cur_status_q <= cur_status_d;
      d1_q         <= d1_d;
      o_Msg_Valid  <= msg_valid_d;
      o_Status     <= status_d;
      o_Data1      <= data1_d;
      o_Data2      <= data2_d;
      o_Msg_Len    <= len_d;
      o_Rt_Valid   <= rt_valid_d;
      o_Rt_Byte    <= rt_byte_d;
      o_Sx_Valid   <= sx_valid_d;
      o_Sx_Byte    <= sx_byte_d;
      o_Sx_Last    <= sx_last_d;
      o_Err        <= err_d;
    end
  end

endmodule
